// File: rtl/reg_scoreboard.sv
// In-order register scoreboard: tracks the rd of every in-flight instruction from
// ID to WB and raises the ID stall on RAW hazards against rs1/rs2 or on queue-full.
module reg_scoreboard #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [6:0]       issue_opcode,
   input  logic [4:0]       issue_rs1,
   input  logic [4:0]       issue_rs2,
   input  logic [4:0]       issue_rd,
   input  logic             issue_regWrite,
   input  logic             retire_valid,
   input  logic             flush,
   input  logic [1:0]       flush_count,
   output logic             stall,
   output logic             full,
   output logic [PTR_W:0]   count,
   output logic [31:0]      busy_mask
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_q, full_d;
   logic [DEPTH-1:0] we_q, we_d;
   logic [4:0]       rd_q [DEPTH];
   logic [4:0]       rd_d [DEPTH];

   logic             rd1_s, rd2_s, hazard_s, stall_s, accept_s, pop_s;
   logic [31:0]      busy_s;
   logic [PTR_W:0]   count_ret_s, fc_ext_s, drop_n_s;

   // Source-operand read enables decoded from the issuing opcode.
   always_comb begin
      rd1_s = 1'b0;
      rd2_s = 1'b0;
      case (issue_opcode)
         OP_R, OP_STORE, OP_BRANCH: begin
            rd1_s = 1'b1;
            rd2_s = 1'b1;
         end
         OP_I, OP_LOAD, OP_JALR: begin
            rd1_s = 1'b1;
            rd2_s = 1'b0;
         end
         default: begin
            rd1_s = 1'b0;
            rd2_s = 1'b0;
         end
      endcase
   end

   // Busy mask from entry registers; invalid entries always hold we=0.
   always_comb begin
      busy_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_s[rd_q[i]] = busy_s[rd_q[i]] | we_q[i];
      end
   end

   assign busy_mask = {busy_s[31:1], 1'b0};
   assign hazard_s  = (rd1_s & (issue_rs1 != 5'd0) & busy_mask[issue_rs1]) |
                      (rd2_s & (issue_rs2 != 5'd0) & busy_mask[issue_rs2]);
   assign stall_s   = issue_valid & ~flush & (hazard_s | full_q);
   assign accept_s  = issue_valid & ~stall_s & ~flush;
   assign pop_s     = retire_valid & (count_q != '0);
   assign stall     = stall_s;
   assign full      = full_q;
   assign count     = count_q;

   // Next state: retire pops first, flush trims what remains, issue pushes only without flush.
   always_comb begin
      logic [PTR_W-1:0] dist_v;
      dist_v      = '0;
      count_ret_s = count_q - {{PTR_W{1'b0}}, pop_s};
      fc_ext_s    = (PTR_W+1)'(flush_count);
      if (flush) begin
         drop_n_s = (fc_ext_s < count_ret_s) ? fc_ext_s : count_ret_s;
      end else begin
         drop_n_s = '0;
      end
      head_d  = head_q + PTR_W'(pop_s);
      tail_d  = tail_q - drop_n_s[PTR_W-1:0] + PTR_W'(accept_s);
      count_d = count_ret_s - drop_n_s + (PTR_W+1)'(accept_s);
      full_d  = (count_d == (PTR_W+1)'(DEPTH));
      we_d    = we_q;
      rd_d    = rd_q;
      we_d[head_q] = we_q[head_q] & ~pop_s;
      for (int i = 0; i < DEPTH; i++) begin
         dist_v  = tail_q - PTR_W'(i);
         we_d[i] = we_d[i] & ~((dist_v != '0) & ({1'b0, dist_v} <= drop_n_s));
      end
      we_d[tail_q] = accept_s ? (issue_regWrite & (issue_rd != 5'd0)) : we_d[tail_q];
      rd_d[tail_q] = accept_s ? issue_rd : rd_q[tail_q];
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         we_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i] <= 5'd0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= full_d;
         we_q    <= we_d;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i] <= rd_d[i];
         end
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and short random bench for reg_scoreboard using a queue-based reference
// model; expected registered outputs are queued at drive time and popped after the edge.
module tb_reg_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [6:0]  issue_opcode;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_regWrite;
   logic        retire_valid;
   logic        flush;
   logic [1:0]  flush_count;
   logic        stall, full;
   logic [2:0]  count;
   logic [31:0] busy_mask;

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] BR = 7'b1100011;
   localparam logic [6:0] JR = 7'b1100111;
   localparam logic [6:0] JL = 7'b1101111;
   localparam logic [6:0] LU = 7'b0110111;
   localparam logic [6:0] AU = 7'b0010111;

   typedef struct packed {
      logic [2:0]  cnt;
      logic        fl;
      logic [31:0] busy;
   } exp_t;

   logic [5:0] mq[$];
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   reg_scoreboard #(.DEPTH(4), .PTR_W(2)) dut (
      .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
      .issue_regWrite(issue_regWrite), .retire_valid(retire_valid), .flush(flush),
      .flush_count(flush_count), .stall(stall), .full(full), .count(count),
      .busy_mask(busy_mask)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = 32'd0;
      foreach (mq[k]) if (mq[k][5]) b[mq[k][4:0]] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   function automatic logic reads1(input logic [6:0] op);
      return (op == R) || (op == I) || (op == ST) || (op == LD) || (op == BR) || (op == JR);
   endfunction

   function automatic logic reads2(input logic [6:0] op);
      return (op == R) || (op == ST) || (op == BR);
   endfunction

   task automatic pop_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_count"}, 32'(count), 32'(e.cnt));
         chk({tag, "_full"}, 32'(full), 32'(e.fl));
         chk({tag, "_busy"}, busy_mask, e.busy);
      end
   endtask

   // One cycle: drive, check stall against the model, update model, compare after the edge.
   task automatic step(input string tag, input logic iv, input logic [6:0] op,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic rw, input logic ret, input logic fl, input logic [1:0] fc);
      logic [31:0] b;
      logic        exp_stall;
      int          n;
      exp_t        e;
      issue_valid = iv; issue_opcode = op; issue_rs1 = s1; issue_rs2 = s2; issue_rd = d;
      issue_regWrite = rw; retire_valid = ret; flush = fl; flush_count = fc;
      #1;
      b = model_busy();
      exp_stall = iv & ~fl & ((reads1(op) & (s1 != 5'd0) & b[s1]) |
                              (reads2(op) & (s2 != 5'd0) & b[s2]) | (mq.size() == 4));
      chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
      if (ret && mq.size() > 0) void'(mq.pop_front());
      if (fl) begin
         n = (int'(fc) < mq.size()) ? int'(fc) : mq.size();
         repeat (n) void'(mq.pop_back());
      end else if (iv && !exp_stall) begin
         mq.push_back({rw & (d != 5'd0), d});
      end
      e.cnt = 3'(mq.size()); e.fl = (mq.size() == 4); e.busy = model_busy();
      sb.push_back(e);
      @(posedge clock); #1;
      pop_compare(tag);
      @(negedge clock);
   endtask

   task automatic do_reset(input string tag);
      exp_t e;
      reset = 1'b1; issue_valid = 1'b1; issue_opcode = R; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
      issue_rd = 5'd9; issue_regWrite = 1'b1; retire_valid = 1'b0; flush = 1'b0; flush_count = 2'd0;
      mq.delete();
      e.cnt = 3'd0; e.fl = 1'b0; e.busy = 32'd0;
      sb.push_back(e);
      @(posedge clock); #1;
      pop_compare(tag);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [6:0] ops [9];
      ops = '{R, I, ST, LD, BR, JR, JL, LU, AU};
      reset = 1'b1; issue_valid = 1'b0; issue_opcode = 7'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      issue_rd = 5'd0; issue_regWrite = 1'b0; retire_valid = 1'b0; flush = 1'b0; flush_count = 2'd0;
      @(negedge clock);

      // Reset and idle, retire on empty ignored.
      do_reset("rst");
      step("idle0", 1'b0, R, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0);
      step("idle_ret", 1'b0, R, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0);
      step("idle_fl", 1'b1, BR, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 2'd3);

      // rs2 RAW hazard; retire does not bypass the stall.
      do_reset("rst2");
      step("add5", 1'b1, R, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0);
      step("raw2", 1'b1, R, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0);
      step("raw2_ret", 1'b1, R, 5'd0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 2'd0);
      chk("raw2_busy5", 32'(busy_mask[5]), 32'd0);
      step("raw2_go", 1'b1, R, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0);
      step("raw2_drain", 1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0);

      // x0 never busy; JAL/LUI never stall on the rs1 field.
      do_reset("rst3");
      step("x0", 1'b1, I, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0);
      step("rd7", 1'b1, LD, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0);
      step("x0_rs1", 1'b1, I, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 2'd0);
      step("jal7", 1'b1, JL, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("jal_count", 32'(count), 32'd4);
      step("lui7_full", 1'b1, LU, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 2'd1);
      step("lui7", 1'b1, LU, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      chk("lui_nostall", 32'(stall), 32'd0);
      step("jalr7", 1'b1, JR, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0);

      // Fill to DEPTH, stall on full even with same-cycle retire.
      do_reset("rst4");
      for (int k = 1; k <= 4; k++) step("fill", 1'b1, R, 5'd0, 5'd0, 5'(k), 1'b1, 1'b0, 1'b0, 2'd0);
      chk("fill_full", 32'(full), 32'd1);
      step("fifth", 1'b1, I, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0);
      step("fifth_ret", 1'b1, I, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd0);
      chk("fifth_ret_cnt", 32'(count), 32'd3);
      step("fifth_go", 1'b1, I, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("fifth_go_cnt", 32'(count), 32'd4);

      // Retire + flush together; same-cycle issue suppressed.
      do_reset("rst5");
      for (int k = 1; k <= 3; k++) step("f3", 1'b1, I, 5'd0, 5'd0, 5'(k), 1'b1, 1'b0, 1'b0, 2'd0);
      step("rfl", 1'b1, I, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 2'd2);
      chk("rfl_cnt", 32'(count), 32'd0);
      chk("rfl_busy", busy_mask, 32'd0);

      // Short random mix against the model.
      do_reset("rst6");
      for (int k = 0; k < 60; k++) begin
         step("rnd", 1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 8)],
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
      end

      // Pointer wrap, then reset mid-stream.
      do_reset("rst7");
      step("w0", 1'b1, R, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < 10; k++) step("wrap", 1'b1, R, 5'd0, 5'd0, 5'(21 + k), 1'b1, 1'b1, 1'b0, 2'd0);
      step("w2", 1'b1, ST, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0);
      chk("w2_cnt", 32'(count), 32'd2);
      do_reset("rst_mid");
      step("post_rst", 1'b1, R, 5'd30, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
